// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath width, base opcodes, decoded control bundle.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic reg_we;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: combinational, instruction word to sign-extended immediate.
// Zero for R-type and unknown opcodes.
module imm_gen #(
  parameter int W = rv32_pkg::XLEN
) (
  input  logic [31:0]  instr,
  output logic [W-1:0] imm
);
  import rv32_pkg::*;

  logic [31:0] imm32;

  always_comb begin
    imm32 = 32'h0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                         instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'h000};
      OP_JAL:                   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                         instr[20], instr[30:21], 1'b0};
      default:                  imm32 = 32'h0;
    endcase
  end

  assign imm = {{(W-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decode, operand read with writeback bypass, ID/EX register; one-cycle latency.
// Load-use hazards stall fetch and inject a bubble; flush from EX overrides the stall.
module decode_stage #(
  parameter int XLEN      = rv32_pkg::XLEN,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic                 stall_out,
  output logic [NREG_BITS-1:0] rf_r_add1,
  output logic [NREG_BITS-1:0] rf_r_add2,
  input  logic [XLEN-1:0]      rf_r_data1,
  input  logic [XLEN-1:0]      rf_r_data2,
  input  logic                 wb_we,
  input  logic [NREG_BITS-1:0] wb_add,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 ex_mem_read,
  input  logic [NREG_BITS-1:0] ex_rd,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val,
  output logic [NREG_BITS-1:0] out_rs1,
  output logic [NREG_BITS-1:0] out_rs2,
  output logic [NREG_BITS-1:0] out_rd,
  output logic [XLEN-1:0]      out_imm,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic                 out_funct7b5,
  output logic                 out_reg_we,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_branch,
  output logic                 out_jump
);
  import rv32_pkg::*;

  logic [6:0]           opcode;
  logic [NREG_BITS-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]      rs1_val, rs2_val, imm;
  logic                 writes_rd, uses_rs1, uses_rs2, hz;
  ctrl_t                ctrl;

  assign opcode    = in_instr[6:0];
  assign rd        = in_instr[11:7];
  assign rs1       = in_instr[19:15];
  assign rs2       = in_instr[24:20];
  assign rf_r_add1 = rs1;
  assign rf_r_add2 = rs2;

  always_comb begin
    writes_rd      = 1'b0;
    uses_rs1       = 1'b1;
    uses_rs2       = 1'b0;
    ctrl           = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin writes_rd = 1'b1; uses_rs1 = 1'b0; end
      OP_JAL:    begin writes_rd = 1'b1; uses_rs1 = 1'b0; ctrl.jump = 1'b1; end
      OP_JALR:   begin writes_rd = 1'b1; ctrl.jump = 1'b1; end
      OP_BRANCH: begin uses_rs2 = 1'b1; ctrl.branch = 1'b1; end
      OP_LOAD:   begin writes_rd = 1'b1; ctrl.mem_read = 1'b1; end
      OP_STORE:  begin uses_rs2 = 1'b1; ctrl.mem_write = 1'b1; end
      OP_IMM:    writes_rd = 1'b1;
      OP_OP:     begin writes_rd = 1'b1; uses_rs2 = 1'b1; end
      default:   ;
    endcase
    ctrl.reg_we = writes_rd && (rd != '0);
  end

  // The regfile write only lands at the edge, so a same-cycle writeback must be forwarded here.
  assign rs1_val = (wb_we && wb_add != '0 && wb_add == rs1) ? wb_data : rf_r_data1;
  assign rs2_val = (wb_we && wb_add != '0 && wb_add == rs2) ? wb_data : rf_r_data2;

  assign hz = in_valid && ex_mem_read && (ex_rd != '0) &&
              ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
  assign stall_out = rst_n && !flush && hz;

  imm_gen #(.W(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1_val   <= '0;
      out_rs2_val   <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_imm       <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7b5  <= 1'b0;
      out_reg_we    <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_branch    <= 1'b0;
      out_jump      <= 1'b0;
    end else begin
      out_pc       <= in_pc;
      out_rs1_val  <= rs1_val;
      out_rs2_val  <= rs2_val;
      out_rs1      <= rs1;
      out_rs2      <= rs2;
      out_rd       <= rd;
      out_imm      <= imm;
      out_opcode   <= opcode;
      out_funct3   <= in_instr[14:12];
      out_funct7b5 <= in_instr[30];
      if (flush || hz) begin
        out_valid     <= 1'b0;
        out_reg_we    <= 1'b0;
        out_mem_read  <= 1'b0;
        out_mem_write <= 1'b0;
        out_branch    <= 1'b0;
        out_jump      <= 1'b0;
      end else begin
        out_valid     <= in_valid;
        out_reg_we    <= ctrl.reg_we;
        out_mem_read  <= ctrl.mem_read;
        out_mem_write <= ctrl.mem_write;
        out_branch    <= ctrl.branch;
        out_jump      <= ctrl.jump;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: reset sequence, directed vector table, multi-cycle stall/flush
// sequences, then randomized cycles checked against a rule-level reference model.
module tb_decode_stage;

  localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6F, T_JALR = 7'h67;
  localparam logic [6:0] T_BR  = 7'h63, T_LD    = 7'h03, T_ST  = 7'h23, T_IMM  = 7'h13;
  localparam logic [6:0] T_OP  = 7'h33;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, stall_out, wb_we, ex_mem_read;
  logic [31:0] in_instr, in_pc, rf_r_data1, rf_r_data2, wb_data;
  logic [4:0]  rf_r_add1, rf_r_add2, wb_add, ex_rd;
  logic        out_valid, out_funct7b5, out_reg_we, out_mem_read, out_mem_write;
  logic        out_branch, out_jump;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .stall_out(stall_out), .rf_r_add1(rf_r_add1), .rf_r_add2(rf_r_add2),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2), .wb_we(wb_we), .wb_add(wb_add),
    .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .out_valid(out_valid),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_reg_we(out_reg_we), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] instr, pc;
    logic        flush;
    logic [31:0] rf1, rf2;
    logic        wb_we;
    logic [4:0]  wb_add;
    logic [31:0] wb_data;
    logic        ex_mr;
    logic [4:0]  ex_rd;
  } stim_t;

  typedef struct packed {
    logic        valid, stall, bubble;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5, reg_we, mem_read, mem_write, branch, jump;
  } exp_t;

  typedef struct packed {
    stim_t       s;
    logic        e_stall, e_valid, chk_data;
    logic [4:0]  e_rd;
    logic [31:0] e_imm, e_rs1v;
    logic        e_reg_we, e_branch;
  } tv_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic drive(input stim_t s);
    in_valid    = s.valid;
    in_instr    = s.instr;
    in_pc       = s.pc;
    flush       = s.flush;
    rf_r_data1  = s.rf1;
    rf_r_data2  = s.rf2;
    wb_we       = s.wb_we;
    wb_add      = s.wb_add;
    wb_data     = s.wb_data;
    ex_mem_read = s.ex_mr;
    ex_rd       = s.ex_rd;
  endtask

  function automatic stim_t mk(input logic [31:0] instr, input logic [31:0] pc);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.instr = instr;
    s.pc    = pc;
    s.rf2   = 32'h22;
    return s;
  endfunction

  // Reference model built from the ISA encoding rules, not from the stage's structure.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [6:0]  op;
    logic signed [31:0] t;
    logic        u1, u2, hz, wr;
    e  = '0;
    op = s.instr[6:0];
    e.pc = s.pc; e.opcode = op; e.funct3 = s.instr[14:12]; e.f7b5 = s.instr[30];
    e.rs1 = s.instr[19:15]; e.rs2 = s.instr[24:20]; e.rd = s.instr[11:7];
    e.rs1v = (s.wb_we && s.wb_add != 0 && s.wb_add == e.rs1) ? s.wb_data : s.rf1;
    e.rs2v = (s.wb_we && s.wb_add != 0 && s.wb_add == e.rs2) ? s.wb_data : s.rf2;
    t = 0;
    e.imm = 0;
    if (op inside {T_LD, T_IMM, T_JALR}) begin
      t = {s.instr[31:20], 20'h0};                                   e.imm = t >>> 20;
    end else if (op == T_ST) begin
      t = {s.instr[31:25], s.instr[11:7], 20'h0};                    e.imm = t >>> 20;
    end else if (op == T_BR) begin
      t = {s.instr[31], s.instr[7], s.instr[30:25], s.instr[11:8], 1'b0, 19'h0};
      e.imm = t >>> 19;
    end else if (op inside {T_LUI, T_AUIPC}) begin
      e.imm = s.instr & 32'hFFFF_F000;
    end else if (op == T_JAL) begin
      t = {s.instr[31], s.instr[19:12], s.instr[20], s.instr[30:21], 1'b0, 11'h0};
      e.imm = t >>> 11;
    end
    u1 = !(op inside {T_LUI, T_AUIPC, T_JAL});
    u2 = op inside {T_OP, T_ST, T_BR};
    hz = s.valid && s.ex_mr && s.ex_rd != 0 &&
         ((u1 && s.ex_rd == e.rs1) || (u2 && s.ex_rd == e.rs2));
    e.stall  = hz && !s.flush;
    e.bubble = s.flush || hz;
    if (!e.bubble) begin
      wr          = op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_LD, T_IMM, T_OP};
      e.valid     = s.valid;
      e.reg_we    = wr && e.rd != 0;
      e.mem_read  = op == T_LD;
      e.mem_write = op == T_ST;
      e.branch    = op == T_BR;
      e.jump      = op inside {T_JAL, T_JALR};
    end
    return e;
  endfunction

  task automatic apply_model(input stim_t s);
    exp_t e;
    e = model(s);
    drive(s);
    #1;
    chk("rnd.stall", {31'b0, stall_out}, {31'b0, e.stall});
    chk("rnd.raddr", {22'b0, rf_r_add1, rf_r_add2}, {22'b0, s.instr[19:15], s.instr[24:20]});
    @(posedge clk); #1;
    chk("rnd.valid", {31'b0, out_valid}, {31'b0, e.valid});
    chk("rnd.ctrl", {27'b0, out_reg_we, out_mem_read, out_mem_write, out_branch, out_jump},
        {27'b0, e.reg_we, e.mem_read, e.mem_write, e.branch, e.jump});
    if (!e.bubble) begin
      chk("rnd.pc", out_pc, e.pc);
      chk("rnd.rs1v", out_rs1_val, e.rs1v);
      chk("rnd.rs2v", out_rs2_val, e.rs2v);
      chk("rnd.imm", out_imm, e.imm);
      chk("rnd.idx", {17'b0, out_rs1, out_rs2, out_rd}, {17'b0, e.rs1, e.rs2, e.rd});
      chk("rnd.fields", {21'b0, out_opcode, out_funct3, out_funct7b5},
          {21'b0, e.opcode, e.funct3, e.f7b5});
    end
  endtask

  function automatic tv_t rec(input logic [31:0] instr, input logic [31:0] rf1,
                              input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                              input logic exmr, input logic [4:0] exrd, input logic fl,
                              input logic e_stall, input logic e_valid, input logic chk_data,
                              input logic [4:0] e_rd, input logic [31:0] e_imm,
                              input logic [31:0] e_rs1v, input logic e_reg_we,
                              input logic e_branch);
    tv_t v;
    v.s = mk(instr, 32'h0000_1000);
    v.s.rf1 = rf1; v.s.wb_we = wbwe; v.s.wb_add = wba; v.s.wb_data = wbd;
    v.s.ex_mr = exmr; v.s.ex_rd = exrd; v.s.flush = fl;
    v.e_stall = e_stall; v.e_valid = e_valid; v.chk_data = chk_data; v.e_rd = e_rd;
    v.e_imm = e_imm; v.e_rs1v = e_rs1v; v.e_reg_we = e_reg_we; v.e_branch = e_branch;
    return v;
  endfunction

  tv_t   tv[14];
  stim_t s;
  logic [6:0] ops[11];

  initial begin
    //             instr         rf1    we a  wb_data   mr rd fl  st v  c  rd  imm           rs1v   we br
    tv[0]  = rec(32'hFFF00293, 32'h0,  0, 0, 32'h0,    0, 0, 0,  0, 1, 1, 5,  32'hFFFFFFFF, 32'h0, 1, 0);
    tv[1]  = rec(32'h00118213, 32'h11, 1, 3, 32'hABCD, 0, 0, 0,  0, 1, 1, 4,  32'h1,        32'hABCD, 1, 0);
    tv[2]  = rec(32'h00118213, 32'h11, 1, 0, 32'hABCD, 0, 0, 0,  0, 1, 1, 4,  32'h1,        32'h11, 1, 0);
    tv[3]  = rec(32'h002380B3, 32'h77, 0, 0, 32'h0,    1, 7, 0,  1, 0, 0, 0,  32'h0,        32'h0,  0, 0);
    tv[4]  = rec(32'h002380B3, 32'h77, 0, 0, 32'h0,    0, 7, 0,  0, 1, 1, 1,  32'h0,        32'h77, 1, 0);
    tv[5]  = rec(32'h123453B7, 32'h0,  0, 0, 32'h0,    1, 7, 0,  0, 1, 1, 7,  32'h12345000, 32'h0,  1, 0);
    tv[6]  = rec(32'h000000B3, 32'h0,  0, 0, 32'h0,    1, 0, 0,  0, 1, 1, 1,  32'h0,        32'h0,  1, 0);
    tv[7]  = rec(32'h002380B3, 32'h77, 0, 0, 32'h0,    1, 7, 1,  0, 0, 0, 0,  32'h0,        32'h0,  0, 0);
    tv[8]  = rec(32'hFE000CE3, 32'h0,  0, 0, 32'h0,    0, 0, 0,  0, 1, 1, 25, 32'hFFFFFFF8, 32'h0,  0, 1);
    tv[9]  = rec(32'h0000007F, 32'h0,  0, 0, 32'h0,    0, 0, 0,  0, 1, 1, 0,  32'h0,        32'h0,  0, 0);
    tv[10] = rec(32'h0020A223, 32'h55, 0, 0, 32'h0,    0, 0, 0,  0, 1, 1, 4,  32'h4,        32'h55, 0, 0);
    tv[11] = rec(32'h00500013, 32'h0,  0, 0, 32'h0,    0, 0, 0,  0, 1, 1, 0,  32'h5,        32'h0,  0, 0);
    tv[12] = rec(32'h0070A023, 32'h0,  0, 0, 32'h0,    1, 7, 0,  1, 0, 0, 0,  32'h0,        32'h0,  0, 0);
    tv[13] = rec(32'h00700093, 32'h0,  0, 0, 32'h0,    1, 7, 0,  0, 1, 1, 1,  32'h7,        32'h0,  1, 0);

    // Reset held two cycles with a hazard pending: stall must stay low, outputs cleared.
    rst_n = 1'b0;
    s = mk(32'h002380B3, 32'h0000_0040);
    s.ex_mr = 1'b1; s.ex_rd = 5'd7;
    drive(s);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst.stall", {31'b0, stall_out}, 32'h0);
      chk("rst.valid", {31'b0, out_valid}, 32'h0);
      chk("rst.imm", out_imm, 32'h0);
      chk("rst.reg_we", {31'b0, out_reg_we}, 32'h0);
    end
    rst_n = 1'b1;
    drive(mk(32'hFFF00293, 32'h0000_0080));
    #1;
    chk("rst.hold_before_edge", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("rst.first_capture_valid", {31'b0, out_valid}, 32'h1);
    chk("rst.first_capture_pc", out_pc, 32'h0000_0080);

    for (int i = 0; i < 14; i++) begin
      tv[i].s.pc = 32'h1000 + 32'(i) * 4;
      drive(tv[i].s);
      #1;
      chk($sformatf("tv%0d.stall", i), {31'b0, stall_out}, {31'b0, tv[i].e_stall});
      chk($sformatf("tv%0d.raddr1", i), {27'b0, rf_r_add1}, {27'b0, tv[i].s.instr[19:15]});
      @(posedge clk); #1;
      chk($sformatf("tv%0d.valid", i), {31'b0, out_valid}, {31'b0, tv[i].e_valid});
      chk($sformatf("tv%0d.reg_we", i), {31'b0, out_reg_we}, {31'b0, tv[i].e_reg_we});
      chk($sformatf("tv%0d.branch", i), {31'b0, out_branch}, {31'b0, tv[i].e_branch});
      if (tv[i].chk_data) begin
        chk($sformatf("tv%0d.rd", i), {27'b0, out_rd}, {27'b0, tv[i].e_rd});
        chk($sformatf("tv%0d.imm", i), out_imm, tv[i].e_imm);
        chk($sformatf("tv%0d.rs1v", i), out_rs1_val, tv[i].e_rs1v);
        chk($sformatf("tv%0d.pc", i), out_pc, tv[i].s.pc);
      end
    end

    // Load-use hazard held for two cycles, then released; then a flushed store.
    s = mk(32'h002380B3, 32'h0000_2000);
    s.ex_mr = 1'b1; s.ex_rd = 5'd7;
    drive(s);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("seq.stall_held", {31'b0, stall_out}, 32'h1);
      @(posedge clk); #1;
      chk("seq.bubble", {31'b0, out_valid}, 32'h0);
    end
    ex_mem_read = 1'b0;
    #1;
    chk("seq.stall_release", {31'b0, stall_out}, 32'h0);
    @(posedge clk); #1;
    chk("seq.capture_valid", {31'b0, out_valid}, 32'h1);
    chk("seq.capture_pc", out_pc, 32'h0000_2000);
    drive(mk(32'h0020A223, 32'h0000_2004));
    flush = 1'b1;
    @(posedge clk); #1;
    chk("seq.flush_valid", {31'b0, out_valid}, 32'h0);
    chk("seq.flush_mem_write", {31'b0, out_mem_write}, 32'h0);

    ops = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_IMM, T_OP, 7'h7F, 7'h0B};
    for (int n = 0; n < 400; n++) begin
      s = '0;
      s.instr = $urandom;
      s.instr[6:0] = ops[$urandom_range(0, 10)];
      s.pc    = $urandom & 32'hFFFF_FFFC;
      s.valid = ($urandom_range(0, 7) != 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.rf1   = (s.instr[19:15] == 0) ? 32'h0 : $urandom;
      s.rf2   = (s.instr[24:20] == 0) ? 32'h0 : $urandom;
      s.wb_we = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       s.wb_add = s.instr[19:15];
        1:       s.wb_add = s.instr[24:20];
        default: s.wb_add = 5'($urandom);
      endcase
      s.wb_data = $urandom;
      s.ex_mr   = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       s.ex_rd = s.instr[19:15];
        1:       s.ex_rd = s.instr[24:20];
        default: s.ex_rd = 5'($urandom);
      endcase
      apply_model(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the single-issue RISC-V RV32I pipeline.
- Combinationally decodes the IF/ID instruction and drives the register file read addresses.
- Merges the register file read data with a writeback bypass and generates the immediate.
- Registers everything into the ID/EX pipeline register; detects load-use hazards, stalls fetch and inserts bubbles.

Parameters:
- XLEN, 32, datapath width.
- NREG_BITS, 5, register address width (32 architectural registers, x0 hardwired zero).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  IF/ID holds a valid instruction.
- in_instr  input  32  instruction word from IF/ID.
- in_pc  input  32  PC of in_instr.
- flush  input  1  branch/jump redirect from EX; kill the instruction in ID.
- stall_out  output  1  hold PC and IF/ID this cycle (load-use hazard).
- rf_r_add1  output  5  register file read address 1 = in_instr[19:15].
- rf_r_add2  output  5  register file read address 2 = in_instr[24:20].
- rf_r_data1  input  32  register file read data 1 (x0 already returns 0).
- rf_r_data2  input  32  register file read data 2.
- wb_we  input  1  writeback write enable, same signal as register file we.
- wb_add  input  5  writeback destination.
- wb_data  input  32  writeback data.
- ex_mem_read  input  1  instruction currently in EX is a load.
- ex_rd  input  5  destination of the instruction in EX.
- out_valid  output  1  ID/EX holds a valid instruction.
- out_pc  output  32  registered PC.
- out_rs1_val, out_rs2_val  output  32 each  registered operands.
- out_rs1, out_rs2, out_rd  output  5 each  registered register indices (for EX forwarding).
- out_imm  output  32  registered sign-extended immediate.
- out_opcode  output  7; out_funct3  output  3; out_funct7b5  output  1  registered decode fields.
- out_reg_we, out_mem_read, out_mem_write, out_branch, out_jump  output  1 each  registered control.

Behaviour:
- Reset: when rst_n=0 at a rising edge, every registered output and out_valid go to 0 and stay 0 until rst_n=1.
- stall_out is combinational and forced to 0 while rst_n=0.
- Latency: one cycle. Inputs sampled at edge N appear on the out_* ports after edge N.
- rf_r_add1 and rf_r_add2 are always driven from in_instr, even when in_valid=0.
- Bypass: operand k = wb_data if wb_we=1 and wb_add!=0 and wb_add==rs_k; otherwise rf_r_data_k. This covers a same-cycle write, since the register file write lands only at the edge.
- uses_rs1: false for LUI, AUIPC and JAL.
- uses_rs2: true only for R-type, STORE and BRANCH.
- Hazard: hz = in_valid and ex_mem_read and ex_rd!=0 and ((uses_rs1 and ex_rd==rs1) or (uses_rs2 and ex_rd==rs2)).
- Priority at each edge:
  1. flush=1: out_valid<=0, stall_out=0, and all control bits are cleared.
  2. Otherwise hz=1: stall_out=1 and a bubble is inserted (out_valid<=0, control bits cleared). The same instruction re-decodes next cycle.
  3. Otherwise: capture everything, out_valid<=in_valid.
- When a bubble is inserted, out_rs*_val and out_imm may hold any value.
- Immediate by opcode:
  - I-type (LOAD, OP-IMM, JALR): instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended to 32 bits; 0 for R-type or unknown opcodes.
- Unknown opcode: out_valid follows in_valid, with all control bits 0 (it passes through as a NOP).
- out_reg_we is forced 0 when rd==0.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants: OP_LUI 0110111, OP_AUIPC 0010111, OP_JAL 1101111, OP_JALR 1100111, OP_BRANCH 1100011, OP_LOAD 0000011, OP_STORE 0100011, OP_IMM 0010011, OP_OP 0110011.
  - XLEN.
- One sub-module, imm_gen: purely combinational, instr to imm.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_imm=0, stall_out=0; first capture happens at the edge after release.
- ADDI x5,x0,-1 (0xFFF00293) -> next cycle out_imm=0xFFFFFFFF, out_rd=5, out_reg_we=1, out_rs1_val=0.
- Bypass: rf_r_data1=0x11, wb_we=1, wb_add=rs1=3, wb_data=0xABCD -> out_rs1_val=0xABCD. Repeat with wb_add=0 -> out_rs1_val=0x11.
- Load-use: ex_mem_read=1, ex_rd=7, ADD x1,x7,x2 in ID -> stall_out=1 and one bubble (out_valid=0). With ex_mem_read dropped the next cycle, ADD is captured with out_valid=1.
- No false hazard: ex_rd=7 with LUI x7 in ID -> stall_out=0. ex_rd=0 -> stall_out=0.
- Flush and hazard in the same cycle -> stall_out=0, out_valid=0. BEQ offset -8 (0xFE000CE3) -> out_imm=0xFFFFFFF8, out_branch=1.
